// File: rtl/demux_pkg.sv
// Shared definitions for the two-way streaming demultiplexer.
package demux_pkg;

  // Width of the per-port delivery counters shown on the lab board.
  localparam int CNT_W = 8;

  // Destination encoding carried on the sel input.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_e;

endpackage

// File: rtl/demux_fifo2.sv
// Small synchronous FIFO used as the buffer behind each demux output port.
// The head is registered state only and reads as zero while the FIFO is empty,
// so a pushed word is first visible the cycle after it is written.
module demux_fifo2 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == FILL_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrapping naturally at DEPTH) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FILL_W'(1);
      2'b01:   count_d = count_q - FILL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/demux1t2_stream.sv
// Two-way streaming demultiplexer: each accepted input word is steered by sel
// into one of two FIFOs, each draining through its own valid/ready port, with
// a wrapping delivery counter per port.
module demux1t2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o1,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  port_sel_e        dest;
  logic             accept;
  logic             push0, push1;
  logic             pop0, pop1;
  logic             full0, full1;
  logic             empty0, empty1;
  logic [WIDTH-1:0] head0, head1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // in_ready looks only at sel and registered FIFO state, never at o*_ready.
  assign dest     = port_sel_e'(sel);
  assign in_ready = (dest == PORT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (dest == PORT0);
  assign push1    = accept && (dest == PORT1);

  assign o0_valid = !empty0;
  assign o1_valid = !empty1;
  assign o0       = head0;
  assign o1       = head1;
  assign pop0     = o0_valid && o0_ready;
  assign pop1     = o1_valid && o1_ready;

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

  demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (d),
    .pop       (pop0),
    .head      (head0),
    .full      (full0),
    .empty     (empty0)
  );

  demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (d),
    .pop       (pop1),
    .head      (head1),
    .full      (full1),
    .empty     (empty1)
  );

  // Delivery counters advance on each completed output transfer and wrap at 256.
  always_comb begin
    cnt0_d = pop0 ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d = pop1 ? cnt1_q + CNT_W'(1) : cnt1_q;
  end

  // Counter registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_demux1t2_stream.sv
// Self-checking bench for demux1t2_stream: directed handshake/boundary checks
// plus a per-port scoreboard that predicts delivered words and counters.
module tb_demux1t2_stream;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic [3:0] d;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] o0;
  logic       o0_valid;
  logic       o0_ready;
  logic [3:0] o1;
  logic       o1_valid;
  logic       o1_ready;
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  int assertCount = 0;
  int failCount   = 0;

  logic [3:0] exp0 [$];
  logic [3:0] exp1 [$];
  logic [7:0] mdlCnt0 = 8'd0;
  logic [7:0] mdlCnt1 = 8'd0;

  demux1t2_stream #(.WIDTH(4), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .d        (d),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0       (o0),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o1       (o1),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive all producer/consumer inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic s, input logic [3:0] data,
                               input logic r0, input logic r1);
    in_valid = v;
    sel      = s;
    d        = data;
    o0_ready = r0;
    o1_ready = r1;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: at the falling edge, predict the transfers of the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp0.delete();
      exp1.delete();
      mdlCnt0 = 8'd0;
      mdlCnt1 = 8'd0;
    end else begin
      checkOutput("cnt0", {24'd0, cnt0}, {24'd0, mdlCnt0});
      checkOutput("cnt1", {24'd0, cnt1}, {24'd0, mdlCnt1});
      if (!o0_valid) checkOutput("o0_zero_when_empty", {28'd0, o0}, 32'd0);
      if (!o1_valid) checkOutput("o1_zero_when_empty", {28'd0, o1}, 32'd0);
      if (o0_valid && o0_ready) begin
        if (exp0.size() == 0) checkOutput("o0_unexpected_word", {31'd0, o0_valid}, 32'd0);
        else checkOutput("o0_data", {28'd0, o0}, {28'd0, exp0.pop_front()});
        mdlCnt0 = mdlCnt0 + 8'd1;
      end
      if (o1_valid && o1_ready) begin
        if (exp1.size() == 0) checkOutput("o1_unexpected_word", {31'd0, o1_valid}, 32'd0);
        else checkOutput("o1_data", {28'd0, o1}, {28'd0, exp1.pop_front()});
        mdlCnt1 = mdlCnt1 + 8'd1;
      end
      if (in_valid && in_ready) begin
        if (sel) exp1.push_back(d);
        else     exp0.push_back(d);
      end
    end
  end

  // Directed sequence covering reset, routing, backpressure, concurrency and wrap.
  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 4'h0, 0, 0);
    tick();
    tick();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_o0_valid", {31'd0, o0_valid}, 32'd0);
    checkOutput("rst_o1_valid", {31'd0, o1_valid}, 32'd0);
    checkOutput("rst_cnt0", {24'd0, cnt0}, 32'd0);
    rst_n = 1'b1;

    // Routing: 1010 to port 0, then 0001 to port 1.
    applyStimulus(1, 0, 4'b1010, 1, 1);
    checkOutput("route_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("route_o0_valid", {31'd0, o0_valid}, 32'd1);
    checkOutput("route_o0", {28'd0, o0}, 32'hA);
    applyStimulus(1, 1, 4'b0001, 1, 1);
    tick();
    checkOutput("route_o0_gone", {31'd0, o0_valid}, 32'd0);
    checkOutput("route_o1_valid", {31'd0, o1_valid}, 32'd1);
    checkOutput("route_o1", {28'd0, o1}, 32'h1);
    applyStimulus(0, 0, 4'h0, 1, 1);
    tick();
    checkOutput("route_cnt0", {24'd0, cnt0}, 32'd1);
    checkOutput("route_cnt1", {24'd0, cnt1}, 32'd1);

    // Fill and backpressure on port 0.
    applyStimulus(1, 0, 4'h1, 0, 0);
    tick();
    applyStimulus(1, 0, 4'h2, 0, 0);
    checkOutput("fill_ready_after1", {31'd0, in_ready}, 32'd1);
    tick();
    applyStimulus(1, 0, 4'h3, 0, 0);
    checkOutput("fill_ready_full", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("fill_still_full", {31'd0, in_ready}, 32'd0);
    applyStimulus(1, 0, 4'h3, 1, 0);
    checkOutput("fill_head", {28'd0, o0}, 32'h1);
    tick();
    applyStimulus(1, 0, 4'h3, 0, 0);
    checkOutput("fill_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("fill_full_again", {31'd0, in_ready}, 32'd0);
    applyStimulus(0, 0, 4'h0, 1, 0);
    tick();
    tick();
    checkOutput("fill_drained", {31'd0, o0_valid}, 32'd0);
    checkOutput("fill_cnt0", {24'd0, cnt0}, 32'd4);

    // Concurrent push/pop on port 1 holding occupancy at one.
    applyStimulus(1, 1, 4'h0, 0, 0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 1, i[3:0], 0, 1);
      checkOutput("conc_o1_valid", {31'd0, o1_valid}, 32'd1);
      checkOutput("conc_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("conc_o1_head", {28'd0, o1}, {28'd0, 4'(i - 1)});
      tick();
    end
    checkOutput("conc_cnt1", {24'd0, cnt1}, 32'd11);
    applyStimulus(0, 0, 4'h0, 0, 1);
    tick();
    checkOutput("conc_drained", {31'd0, o1_valid}, 32'd0);
    checkOutput("conc_cnt1_end", {24'd0, cnt1}, 32'd12);

    // Independence: port 0 stalled full while port 1 streams.
    applyStimulus(1, 0, 4'h5, 0, 0);
    tick();
    applyStimulus(1, 0, 4'h6, 0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 4'h0, 0, 1);
      checkOutput("indep_ready_sel0", {31'd0, in_ready}, 32'd0);
      applyStimulus(1, 1, 4'(8 + i), 0, 1);
      checkOutput("indep_ready_sel1", {31'd0, in_ready}, 32'd1);
      tick();
      checkOutput("indep_o1_valid", {31'd0, o1_valid}, 32'd1);
      checkOutput("indep_o1", {28'd0, o1}, {28'd0, 4'(8 + i)});
    end
    applyStimulus(0, 0, 4'h0, 1, 1);
    tick();
    tick();
    tick();
    checkOutput("indep_o0_drained", {31'd0, o0_valid}, 32'd0);
    checkOutput("indep_cnt0", {24'd0, cnt0}, 32'd6);
    checkOutput("indep_cnt1", {24'd0, cnt1}, 32'd20);

    // Reset mid-cycle with words buffered on both ports.
    applyStimulus(1, 0, 4'h7, 0, 0);
    tick();
    applyStimulus(1, 1, 4'h9, 0, 0);
    tick();
    applyStimulus(0, 0, 4'h0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_o0_valid", {31'd0, o0_valid}, 32'd0);
    checkOutput("arst_o1_valid", {31'd0, o1_valid}, 32'd0);
    checkOutput("arst_o0", {28'd0, o0}, 32'd0);
    checkOutput("arst_o1", {28'd0, o1}, 32'd0);
    checkOutput("arst_cnt0", {24'd0, cnt0}, 32'd0);
    checkOutput("arst_cnt1", {24'd0, cnt1}, 32'd0);
    checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 0, 4'h0, 1, 1);
    tick();
    tick();
    checkOutput("post_rst_o0_valid", {31'd0, o0_valid}, 32'd0);
    checkOutput("post_rst_o1_valid", {31'd0, o1_valid}, 32'd0);

    // Counter wrap: 257 deliveries on port 0.
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1, 0, i[3:0], 1, 0);
      tick();
    end
    applyStimulus(0, 0, 4'h0, 1, 0);
    tick();
    checkOutput("wrap_cnt0", {24'd0, cnt0}, 32'd1);
    checkOutput("wrap_cnt1", {24'd0, cnt1}, 32'd0);
    checkOutput("sb0_empty", exp0.size(), 32'd0);
    checkOutput("sb1_empty", exp1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
